// File: rtl/municao_pool.sv
// Bullet pool: allocates lowest free slot on fire, moves active slots per tick, paints RGB layer.
// Latency: slot state/ack/drop one cycle after the sampling edge; pixel path combinational; no backpressure, refusals pulse fire_drop.
module municao_pool #(
    parameter int          N_SLOTS  = 4,
    parameter int          SPEED    = 4,
    parameter int          TICK_DIV = 500000,
    parameter int          COOLDOWN = 3,
    parameter int          DIR      = 0,
    parameter int          Y_MIN    = 16,
    parameter int          Y_MAX    = 464,
    parameter int          BULLET_W = 2,
    parameter int          BULLET_H = 8,
    parameter logic [23:0] COLOR    = 24'hFFFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fire,
    input  logic [10:0]            fire_x,
    input  logic [10:0]            fire_y,
    input  logic [N_SLOTS-1:0]     hit,
    input  logic [9:0]             h_counter,
    input  logic [9:0]             v_counter,
    output logic [N_SLOTS-1:0]     active,
    output logic [11*N_SLOTS-1:0]  pos_x,
    output logic [11*N_SLOTS-1:0]  pos_y,
    output logic                   fire_ack,
    output logic                   fire_drop,
    output logic [7:0]             R,
    output logic [7:0]             G,
    output logic [7:0]             B
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]          cooldown_q, cooldown_d;
    logic [N_SLOTS-1:0]     active_q, active_d;
    logic [11*N_SLOTS-1:0]  pos_x_q, pos_x_d;
    logic [11*N_SLOTS-1:0]  pos_y_q, pos_y_d;
    logic                   fire_ack_q, fire_drop_q;

    logic                   tick;
    logic [N_SLOTS-1:0]     free, alloc_oh;
    logic                   can_fire, accept, drop;
    logic [11:0]            y12;

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // A slot being hit this cycle is still active, so it is never counted as free.
    assign free     = ~active_q;
    assign alloc_oh = free & (~free + N_SLOTS'(1));
    assign can_fire = fire && (cooldown_q == '0);
    assign accept   = can_fire && (|free);
    assign drop     = can_fire && !(|free);

    always_comb begin
        cooldown_d = cooldown_q;
        if (accept) begin
            cooldown_d = CW'(COOLDOWN);
        end else if (tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CW'(1);
        end
    end

    always_comb begin
        active_d = active_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        y12      = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            y12 = {1'b0, pos_y_q[11*i +: 11]};
            if (accept && alloc_oh[i]) begin
                active_d[i]          = 1'b1;
                pos_x_d[11*i +: 11]  = fire_x;
                pos_y_d[11*i +: 11]  = fire_y;
            end else if (active_q[i] && hit[i]) begin
                active_d[i] = 1'b0;
            end else if (active_q[i] && tick) begin
                // 12-bit compares keep the edge test from wrapping near 0 or 2047.
                if (DIR == 0) begin
                    if (y12 < 12'(Y_MIN + SPEED)) begin
                        active_d[i] = 1'b0;
                    end else begin
                        pos_y_d[11*i +: 11] = pos_y_q[11*i +: 11] - 11'(SPEED);
                    end
                end else begin
                    if ((y12 + 12'(SPEED)) > 12'(Y_MAX)) begin
                        active_d[i] = 1'b0;
                    end else begin
                        pos_y_d[11*i +: 11] = pos_y_q[11*i +: 11] + 11'(SPEED);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            cooldown_q  <= '0;
            active_q    <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            fire_ack_q  <= 1'b0;
            fire_drop_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            cooldown_q  <= cooldown_d;
            active_q    <= active_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            fire_ack_q  <= accept;
            fire_drop_q <= drop;
        end
    end

    logic        px_on;
    logic [11:0] px_x, px_y, h12, v12;

    always_comb begin
        px_on = 1'b0;
        px_x  = '0;
        px_y  = '0;
        h12   = {2'b00, h_counter};
        v12   = {2'b00, v_counter};
        for (int i = 0; i < N_SLOTS; i++) begin
            px_x = {1'b0, pos_x_q[11*i +: 11]};
            px_y = {1'b0, pos_y_q[11*i +: 11]};
            if (active_q[i] &&
                (h12 >= px_x) && (h12 < px_x + 12'(BULLET_W)) &&
                (v12 >= px_y) && (v12 < px_y + 12'(BULLET_H))) begin
                px_on = 1'b1;
            end
        end
    end

    assign {R, G, B}  = px_on ? COLOR : 24'h000000;
    assign active     = active_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign fire_ack   = fire_ack_q;
    assign fire_drop  = fire_drop_q;

endmodule

// File: tb/tb_municao_pool.sv
// Directed bench for municao_pool: an upward pool (TICK_DIV=8, COOLDOWN=2) and a downward pool.
module tb_municao_pool;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fire = 1'b0, fire2 = 1'b0;
    logic [10:0] fire_x = '0, fire_y = '0, fire_y2 = '0;
    logic [3:0]  hit = '0;
    logic [3:0]  hit2 = '0;
    logic [9:0]  h = '0, v = '0;

    logic [3:0]  active, a2;
    logic [43:0] pos_x, pos_y, px2, py2;
    logic        fire_ack, fire_drop, ack2, drop2;
    logic [7:0]  R, G, B, R2, G2, B2;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int nack, ndrop;
    int ack_cyc[4];

    municao_pool #(.N_SLOTS(4), .SPEED(4), .TICK_DIV(8), .COOLDOWN(2), .DIR(0),
                   .Y_MIN(16), .Y_MAX(464), .BULLET_W(2), .BULLET_H(8), .COLOR(24'hFFFFFF)) dut (
        .clk(clk), .reset(reset), .fire(fire), .fire_x(fire_x), .fire_y(fire_y), .hit(hit),
        .h_counter(h), .v_counter(v), .active(active), .pos_x(pos_x), .pos_y(pos_y),
        .fire_ack(fire_ack), .fire_drop(fire_drop), .R(R), .G(G), .B(B));

    municao_pool #(.N_SLOTS(4), .SPEED(4), .TICK_DIV(8), .COOLDOWN(2), .DIR(1),
                   .Y_MIN(16), .Y_MAX(464), .BULLET_W(2), .BULLET_H(8), .COLOR(24'hFFFFFF)) dut_dn (
        .clk(clk), .reset(reset), .fire(fire2), .fire_x(fire_x), .fire_y(fire_y2), .hit(hit2),
        .h_counter(h), .v_counter(v), .active(a2), .pos_x(px2), .pos_y(py2),
        .fire_ack(ack2), .fire_drop(drop2), .R(R2), .G(G2), .B(B2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and land on the following falling edge.
    task automatic adv();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) adv();
    endtask

    task automatic do_reset();
        reset = 1'b1; fire = 1'b0; fire2 = 1'b0; hit = '0;
        adv();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_active", 64'(active), 64'h0);
        chk("rst_pos_x", 64'(pos_x), 64'h0);
        chk("rst_pos_y", 64'(pos_y), 64'h0);
        chk("rst_ack", 64'(fire_ack), 64'h0);
        chk("rst_drop", 64'(fire_drop), 64'h0);
        chk("rst_rgb", 64'({R, G, B}), 64'h0);
        chk("rst_dn_active", 64'(a2), 64'h0);

        // Single shot and movement over 10 ticks
        fire = 1'b1; fire_x = 11'd320; fire_y = 11'd440;
        adv();
        fire = 1'b0;
        chk("t1_active", 64'(active), 64'h1);
        chk("t1_x0", 64'(pos_x[10:0]), 64'd320);
        chk("t1_y0", 64'(pos_y[10:0]), 64'd440);
        chk("t1_ack", 64'(fire_ack), 64'h1);
        adv();
        chk("t1_ack_once", 64'(fire_ack), 64'h0);
        run_to(79);
        chk("t1_y0_9ticks", 64'(pos_y[10:0]), 64'd404);
        adv();
        chk("t1_y0_10ticks", 64'(pos_y[10:0]), 64'd400);

        // Held fire: allocations two ticks apart, then drop when full
        do_reset();
        fire = 1'b1; fire_x = 11'd320; fire_y = 11'd440;
        nack = 0; ndrop = 0;
        while (cyc < 64) begin
            adv();
            if (fire_ack) begin
                if (nack < 4) ack_cyc[nack] = cyc;
                nack++;
            end
            if (fire_drop) ndrop++;
        end
        chk("t2_nack", 64'(nack), 64'd4);
        chk("t2_ack0", 64'(ack_cyc[0]), 64'd1);
        chk("t2_ack1", 64'(ack_cyc[1]), 64'd17);
        chk("t2_ack2", 64'(ack_cyc[2]), 64'd33);
        chk("t2_ack3", 64'(ack_cyc[3]), 64'd49);
        chk("t2_ndrop", 64'(ndrop), 64'd0);
        chk("t2_full", 64'(active), 64'hF);
        adv();
        chk("t2_drop", 64'(fire_drop), 64'h1);
        chk("t2_drop_noack", 64'(fire_ack), 64'h0);
        chk("t2_full_kept", 64'(active), 64'hF);

        // Hits, slot reuse, hit on inactive slot, fire+hit in the same cycle
        adv();
        fire = 1'b0; hit = 4'b1000;
        adv();
        chk("t3_hit3", 64'(active), 64'h7);
        hit = 4'b0010;
        adv();
        chk("t3_hit1", 64'(active), 64'h5);
        hit = 4'b0000; fire = 1'b1; fire_x = 11'd50; fire_y = 11'd300;
        adv();
        chk("t3_reuse", 64'(active), 64'h7);
        chk("t3_reuse_ack", 64'(fire_ack), 64'h1);
        chk("t3_reuse_x1", 64'(pos_x[21:11]), 64'd50);
        chk("t3_reuse_y1", 64'(pos_y[21:11]), 64'd300);
        fire = 1'b0; hit = 4'b1000;
        adv();
        chk("t3_hit_inactive", 64'(active), 64'h7);
        chk("t3_hit_inactive_ack", 64'({fire_ack, fire_drop}), 64'h0);
        hit = 4'b0000;
        run_to(80);
        fire = 1'b1; hit = 4'b0001;
        adv();
        chk("t3_fire_hit", 64'(active), 64'hE);
        chk("t3_fire_hit_ack", 64'(fire_ack), 64'h1);
        chk("t3_fire_hit_x3", 64'(pos_x[43:33]), 64'd50);
        fire = 1'b0; hit = 4'b0000;

        // Edge exit, both directions
        do_reset();
        fire = 1'b1; fire_x = 11'd10; fire_y = 11'd20;
        fire2 = 1'b1; fire_y2 = 11'd462;
        adv();
        fire = 1'b0; fire2 = 1'b0;
        chk("t4_up_alloc", 64'(active), 64'h1);
        chk("t4_dn_alloc", 64'(a2), 64'h1);
        run_to(7);
        chk("t4_dn_pre_tick", 64'(a2), 64'h1);
        chk("t4_up_pre_tick", 64'(pos_y[10:0]), 64'd20);
        adv();
        chk("t4_up_tick1_y", 64'(pos_y[10:0]), 64'd16);
        chk("t4_up_tick1_act", 64'(active), 64'h1);
        chk("t4_dn_exit", 64'(a2), 64'h0);
        run_to(16);
        chk("t4_up_exit", 64'(active), 64'h0);

        // Pixel coverage of a bullet at (100,200)
        do_reset();
        fire = 1'b1; fire_x = 11'd100; fire_y = 11'd200;
        adv();
        fire = 1'b0;
        h = 10'd101; v = 10'd207; #1;
        chk("t5_inside", 64'({R, G, B}), 64'hFFFFFF);
        h = 10'd102; #1;
        chk("t5_right_edge", 64'({R, G, B}), 64'h0);
        h = 10'd101; v = 10'd208; #1;
        chk("t5_bottom_edge", 64'({R, G, B}), 64'h0);
        h = 10'd100; v = 10'd200; #1;
        chk("t5_corner", 64'({R, G, B}), 64'hFFFFFF);
        h = 10'd99; #1;
        chk("t5_left_edge", 64'({R, G, B}), 64'h0);
        h = 10'd0; v = 10'd0;

        // Mid-flight reset with fire still asserted, then immediate acceptance
        do_reset();
        fire = 1'b1; fire_x = 11'd320; fire_y = 11'd440;
        run_to(33);
        chk("t6_three", 64'(active), 64'h7);
        reset = 1'b1;
        adv();
        chk("t6_rst_active", 64'(active), 64'h0);
        chk("t6_rst_ack", 64'(fire_ack), 64'h0);
        chk("t6_rst_pos_y", 64'(pos_y), 64'h0);
        reset = 1'b0;
        adv();
        chk("t6_post_active", 64'(active), 64'h1);
        chk("t6_post_ack", 64'(fire_ack), 64'h1);
        fire = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
